// File: rtl/perm_pkg.sv
// Shared types for the permutator sequencer: program entry layout and FSM states.
package perm_pkg;

    localparam int CFG_W     = 4;
    localparam int DEF_LANES = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_REP_W = 8;
    localparam int DEF_CW    = DEF_LANES * CFG_W;

    typedef struct packed {
        logic [DEF_CW-1:0]    cfg;
        logic [DEF_REP_W-1:0] rep;
        logic                 last;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/permutator_seq_mem.sv
// Program memory: DEPTH entries of {cfg, rep, last}, async-reset flops,
// one write port that only commits in IDLE, combinational read port.
module permutator_seq_mem
    import perm_pkg::*;
#(
    parameter int DEPTH = perm_pkg::DEF_DEPTH,
    parameter int CW    = perm_pkg::DEF_CW,
    parameter int REP_W = perm_pkg::DEF_REP_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  state_e                   state,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_adr,
    input  logic [CW-1:0]            wr_cfg,
    input  logic [REP_W-1:0]         wr_rep,
    input  logic                     wr_last,
    input  logic [$clog2(DEPTH)-1:0] rd_adr,
    output logic [CW-1:0]            rd_cfg,
    output logic [REP_W-1:0]         rd_rep,
    output logic                     rd_last
);

    logic [CW-1:0]    cfg_q  [DEPTH];
    logic [CW-1:0]    cfg_d  [DEPTH];
    logic [REP_W-1:0] rep_q  [DEPTH];
    logic [REP_W-1:0] rep_d  [DEPTH];
    logic             last_q [DEPTH];
    logic             last_d [DEPTH];
    logic             we;

    assign we = wr_en && (state == IDLE);

    always_comb begin
        cfg_d  = cfg_q;
        rep_d  = rep_q;
        last_d = last_q;
        if (we) begin
            cfg_d[wr_adr]  = wr_cfg;
            rep_d[wr_adr]  = wr_rep;
            last_d[wr_adr] = wr_last;
        end
    end

    // A write landing on the entry being read is forwarded, so a start in the
    // same cycle as a write to entry 0 loads the new contents.
    always_comb begin
        rd_cfg  = cfg_q[rd_adr];
        rd_rep  = rep_q[rd_adr];
        rd_last = last_q[rd_adr];
        if (we && (wr_adr == rd_adr)) begin
            rd_cfg  = wr_cfg;
            rd_rep  = wr_rep;
            rd_last = wr_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q  <= '{default: '0};
            rep_q  <= '{default: '0};
            last_q <= '{default: 1'b0};
        end else begin
            cfg_q  <= cfg_d;
            rep_q  <= rep_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/permutator_sequencer.sv
// Streams a stored program of permutation configs to the slice array.
// Optional feature macro: PERM_SEQ_LOOP_EN (adds `loop`, endless repeat until abort).
module permutator_sequencer #(
    parameter int LANES = perm_pkg::DEF_LANES,
    parameter int CFG_W = perm_pkg::CFG_W,
    parameter int DEPTH = perm_pkg::DEF_DEPTH,
    parameter int REP_W = perm_pkg::DEF_REP_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_adr,
    input  logic [LANES*CFG_W-1:0]   wr_cfg,
    input  logic [REP_W-1:0]         wr_rep,
    input  logic                     wr_last,
    input  logic                     start,
    input  logic                     abort,
`ifdef PERM_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    output logic [LANES*CFG_W-1:0]   cfg,
    output logic                     cfg_valid,
    input  logic                     cfg_ready,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    import perm_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = LANES * CFG_W;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [REP_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    cfg_q, cfg_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             loop_q;
`ifdef PERM_SEQ_LOOP_EN
    logic             loop_d;
`else
    assign loop_q = 1'b0;
`endif

    logic [AW-1:0]    rd_adr;
    logic [CW-1:0]    rd_cfg;
    logic [REP_W-1:0] rd_rep;
    logic             rd_last;
    logic             at_end;

    // rep/last of the entry on `cfg` are kept in flops, so the single read
    // port only ever looks at the entry that follows.
    assign at_end = last_q || (ptr_q == AW'(DEPTH - 1));
    assign rd_adr = ((state_q == RUN) && !at_end) ? ptr_q + AW'(1) : '0;

    permutator_seq_mem #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .REP_W (REP_W)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (state_q),
        .wr_en   (wr_en),
        .wr_adr  (wr_adr),
        .wr_cfg  (wr_cfg),
        .wr_rep  (wr_rep),
        .wr_last (wr_last),
        .rd_adr  (rd_adr),
        .rd_cfg  (rd_cfg),
        .rd_rep  (rd_rep),
        .rd_last (rd_last)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        rep_d   = rep_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef PERM_SEQ_LOOP_EN
        loop_d  = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    cfg_d   = rd_cfg;
                    rep_d   = rd_rep;
                    last_d  = rd_last;
                    err_d   = 1'b0;
`ifdef PERM_SEQ_LOOP_EN
                    loop_d  = loop;
`endif
                end
            end
            RUN: begin
                if (wr_en) begin
                    err_d = 1'b1;
                end
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (valid_q && cfg_ready) begin
                    if (cnt_q != rep_q) begin
                        cnt_d = cnt_q + REP_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (at_end && !loop_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            ptr_d  = rd_adr;
                            cfg_d  = rd_cfg;
                            rep_d  = rd_rep;
                            last_d = rd_last;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
            rep_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PERM_SEQ_LOOP_EN
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            rep_q   <= rep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PERM_SEQ_LOOP_EN
            loop_q  <= loop_d;
`endif
        end
    end

    assign cfg       = cfg_q;
    assign cfg_valid = valid_q;
    assign step_idx  = ptr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_permutator_sequencer.sv
// Scoreboard bench for permutator_sequencer: directed programs push expected
// beats/done events; a negedge monitor pops and compares them.
module tb_permutator_sequencer;

    import perm_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 32;
    localparam int REP_W = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_adr = '0;
    logic [CW-1:0] wr_cfg = '0;
    logic [REP_W-1:0] wr_rep = '0;
    logic          wr_last = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop = 1'b0;
    logic [CW-1:0] cfg;
    logic          cfg_valid;
    logic          cfg_ready = 1'b0;
    logic [AW-1:0] step_idx;
    logic          busy;
    logic          done;
    logic          err;

    permutator_sequencer #(
        .LANES (8),
        .CFG_W (4),
        .DEPTH (DEPTH),
        .REP_W (REP_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_adr    (wr_adr),
        .wr_cfg    (wr_cfg),
        .wr_rep    (wr_rep),
        .wr_last   (wr_last),
        .start     (start),
        .abort     (abort),
`ifdef PERM_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .cfg       (cfg),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        logic [CW-1:0] cfg;
        logic [AW-1:0] step;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   xfer_prev = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic void push_beat(logic [CW-1:0] c, logic [AW-1:0] s);
        exp_t e;
        e.is_done = 1'b0;
        e.cfg     = c;
        e.step    = s;
        exp_q.push_back(e);
    endfunction

    function automatic void push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.cfg     = '0;
        e.step    = '0;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares every visible beat (including stalled ones) against the
    // queue head; pops on transfer and on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_kind", 32'(e.is_done), 32'd1);
                        check("done_busy_low", 32'(busy), 32'd0);
                        check("done_valid_low", 32'(cfg_valid), 32'd0);
                        check("done_after_xfer", 32'(xfer_prev), 32'd1);
                    end
                end
                if (cfg_valid) begin
                    if (exp_q.size() == 0) begin
                        if (cfg_ready) check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("beat_kind", 32'(e.is_done), 32'd0);
                        check("beat_cfg", cfg, e.cfg);
                        check("beat_step", 32'(step_idx), 32'(e.step));
                        if (cfg_ready) void'(exp_q.pop_front());
                    end
                end
                xfer_prev = cfg_valid && cfg_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [AW-1:0] adr, input entry_t e);
        wr_en   = 1'b1;
        wr_adr  = adr;
        wr_cfg  = e.cfg;
        wr_rep  = e.rep;
        wr_last = e.last;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        for (int i = 0; i < limit && busy; i++) tick();
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_cfg", cfg, 32'h0);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_step", 32'(step_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Basic program: 0x1 once, then 0x2 three times, done after 4 beats
        write_entry(4'd0, '{cfg: 32'h1, rep: 8'd0, last: 1'b0});
        write_entry(4'd1, '{cfg: 32'h2, rep: 8'd2, last: 1'b1});
        push_beat(32'h1, 4'd0);
        push_beat(32'h2, 4'd1);
        push_beat(32'h2, 4'd1);
        push_beat(32'h2, 4'd1);
        push_done();
        cfg_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic_busy_n1", 32'(busy), 32'd1);
        check("basic_valid_n1", 32'(cfg_valid), 32'd1);
        repeat (4) tick();
        check("basic_done_m1", 32'(done), 32'd1);
        check("basic_busy_m1", 32'(busy), 32'd0);
        drain("basic_drained");

        // Backpressure: same program, ready pattern 1,0,0,1,...
        push_beat(32'h1, 4'd0);
        push_beat(32'h2, 4'd1);
        push_beat(32'h2, 4'd1);
        push_beat(32'h2, 4'd1);
        push_done();
        cfg_ready = pat[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 60; i++) begin
            tick();
            if (!busy) break;
            cfg_ready = pat[i % 4];
        end
        check("bp_finished", 32'(busy), 32'd0);
        drain("bp_drained");

        // Full depth with start-while-busy ignored
        for (int i = 0; i < DEPTH; i++)
            write_entry(AW'(i), '{cfg: 32'h100 + 32'(i), rep: 8'd0, last: 1'b0});
        for (int i = 0; i < DEPTH; i++) push_beat(32'h100 + 32'(i), AW'(i));
        push_done();
        cfg_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(40, "full_finished");
        drain("full_drained");

        // Abort at beat 2 with a write attempted during the run
        write_entry(4'd0, '{cfg: 32'hA0, rep: 8'd3, last: 1'b0});
        write_entry(4'd1, '{cfg: 32'hB1, rep: 8'd0, last: 1'b1});
        push_beat(32'hA0, 4'd0);
        push_beat(32'hA0, 4'd0);
        cfg_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_adr = 4'd0; wr_cfg = 32'hDEAD; wr_rep = 8'd0; wr_last = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        check("abort_err_set", 32'(err), 32'd1);
        cfg_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(cfg_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        drain("abort_drained");
        write_entry(4'd5, '{cfg: 32'h55, rep: 8'd0, last: 1'b0});
        check("err_sticky_idle", 32'(err), 32'd1);

        // Entry 0 must be unchanged by the dropped write; start clears err
        for (int i = 0; i < 4; i++) push_beat(32'hA0, 4'd0);
        push_beat(32'hB1, 4'd1);
        push_done();
        cfg_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        wait_idle(20, "rerun_finished");
        drain("rerun_drained");

        // Write and start in the same cycle: new entry 0 is used
        push_beat(32'hC0, 4'd0);
        push_beat(32'hC0, 4'd0);
        push_done();
        wr_en = 1'b1; wr_adr = 4'd0; wr_cfg = 32'hC0; wr_rep = 8'd1; wr_last = 1'b1;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        wait_idle(20, "wrstart_finished");
        drain("wrstart_drained");

        // start and abort together in IDLE: stay idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_valid", 32'(cfg_valid), 32'd0);
        drain("sa_drained");

        // Reset mid-run clears outputs asynchronously and empties the program
        cfg_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_adr = 4'd3; wr_cfg = 32'h33;
        tick();
        wr_en = 1'b0;
        check("mr_valid_before", 32'(cfg_valid), 32'd1);
        check("mr_err_before", 32'(err), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mr_cfg", cfg, 32'h0);
        check("mr_valid", 32'(cfg_valid), 32'd0);
        check("mr_step", 32'(step_idx), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push_beat(32'h0, AW'(i));
        push_done();
        cfg_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(40, "mr_rerun_finished");
        drain("mr_drained");

`ifdef PERM_SEQ_LOOP_EN
        // Loop mode: 0,1,0,1,... until abort, never done
        write_entry(4'd0, '{cfg: 32'h1, rep: 8'd0, last: 1'b0});
        write_entry(4'd1, '{cfg: 32'h2, rep: 8'd0, last: 1'b1});
        for (int i = 0; i < 3; i++) begin
            push_beat(32'h1, 4'd0);
            push_beat(32'h2, 4'd1);
        end
        cfg_ready = 1'b1;
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        loop = 1'b0;
        repeat (6) tick();
        check("loop_still_busy", 32'(busy), 32'd1);
        cfg_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("loop_abort_valid", 32'(cfg_valid), 32'd0);
        check("loop_abort_busy", 32'(busy), 32'd0);
        drain("loop_drained");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
